// File: rtl/bot_update_sync.sv
// ---------------------------------------------------------------------------
// bot_update_sync
//
// Handshake stage between the rojobot register block and the core's GPIO
// interrupt inputs. Each rising edge of the rojobot update strobe captures a
// coherent 32-bit snapshot {locx, locy, sensors, botinfo} and raises a sticky
// update request that holds until the core acknowledges. One further update
// can wait behind the one being serviced; anything beyond that is dropped and
// (optionally) counted.
//
// States:
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no update pending, o_upd_sync low
//   PEND   | snapshot held, o_upd_sync high, waiting for core acknowledge
//   GAP    | one-cycle low gap after an ack so the core sees a falling edge
//
// Parameters:
//   ACK_SYNC_STAGES  synchronizer depth for i_int_ack (legal 2..4)
//
// Ports:
//   clk            rojobot clock, all logic on rising edge
//   rstn           asynchronous active-low reset
//   i_upd_sysregs  update strobe (rising edge counts)
//   i_locx/i_locy/i_sensors/i_botinfo  live rojobot registers, 8 bits each
//   i_int_ack      core acknowledge, asynchronous level (rising edge counts)
//   i_clr_overrun  synchronous clear of the overrun counter
//   o_upd_sync     update pending / interrupt request
//   o_botinfo      captured snapshot {locx, locy, sensors, botinfo}
//   o_queued       one more update waiting behind the current one
//   o_overrun_cnt  saturating count of dropped updates
//
// Build option:
//   BOTUPD_OVERRUN_CNT_EN  when defined, implements the overrun counter and
//                          i_clr_overrun; otherwise o_overrun_cnt reads 0.
// ---------------------------------------------------------------------------
module bot_update_sync #(
    parameter int ACK_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_upd_sysregs,
    input  logic [7:0]  i_locx,
    input  logic [7:0]  i_locy,
    input  logic [7:0]  i_sensors,
    input  logic [7:0]  i_botinfo,
    input  logic        i_int_ack,
    input  logic        i_clr_overrun,
    output logic        o_upd_sync,
    output logic [31:0] o_botinfo,
    output logic        o_queued,
    output logic [7:0]  o_overrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic                       r_upd_d;
    logic [ACK_SYNC_STAGES-1:0] r_ack_sync;
    logic                       r_ack_d;
    logic                       r_upd_sync;
    logic                       r_queued;
    logic [31:0]                r_botinfo;

    logic                       w_upd_rise;
    logic                       w_ack_rise;
    logic                       w_upd_sync_nxt;
    logic                       w_queued_nxt;
    logic                       w_capture;
    logic                       w_ovr_inc;
    logic [31:0]                w_live;

    assign w_live     = {i_locx, i_locy, i_sensors, i_botinfo};
    assign w_upd_rise = i_upd_sysregs & ~r_upd_d;
    assign w_ack_rise = r_ack_sync[ACK_SYNC_STAGES-1] & ~r_ack_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_upd_d    <= 1'b0;
            r_ack_sync <= '0;
            r_ack_d    <= 1'b0;
            r_upd_sync <= 1'b0;
            r_queued   <= 1'b0;
            r_botinfo  <= 32'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_upd_d    <= i_upd_sysregs;
            r_ack_sync <= {r_ack_sync[ACK_SYNC_STAGES-2:0], i_int_ack};
            r_ack_d    <= r_ack_sync[ACK_SYNC_STAGES-1];
            r_upd_sync <= w_upd_sync_nxt;
            r_queued   <= w_queued_nxt;
            // Whole-word load only, so the core never sees a mixed snapshot.
            if (w_capture) begin
                r_botinfo <= w_live;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_upd_sync_nxt = r_upd_sync;
        w_queued_nxt   = r_queued;
        w_capture      = 1'b0;
        w_ovr_inc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_upd_sync_nxt = 1'b0;
                w_queued_nxt   = 1'b0;
                if (w_upd_rise) begin
                    w_capture      = 1'b1;
                    w_upd_sync_nxt = 1'b1;
                    w_state_nxt    = S_PEND;
                end
            end
            S_PEND: begin
                w_upd_sync_nxt = 1'b1;
                // Queue/overrun accounting applies even when the ack lands
                // in the same cycle.
                if (w_upd_rise) begin
                    if (r_queued) begin
                        w_ovr_inc = 1'b1;
                    end else begin
                        w_queued_nxt = 1'b1;
                    end
                end
                if (w_ack_rise) begin
                    w_upd_sync_nxt = 1'b0;
                    w_state_nxt    = S_GAP;
                end
            end
            S_GAP: begin
                w_upd_sync_nxt = 1'b0;
                // Recapture uses the registers as they are now, not as they
                // were when the update was queued.
                if (r_queued || w_upd_rise) begin
                    w_capture      = 1'b1;
                    w_queued_nxt   = 1'b0;
                    w_upd_sync_nxt = 1'b1;
                    w_state_nxt    = S_PEND;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_upd_sync_nxt = 1'b0;
                w_queued_nxt   = 1'b0;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

`ifdef BOTUPD_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovr_cnt <= 8'h00;
        end else if (i_clr_overrun) begin
            r_ovr_cnt <= 8'h00;
        end else if (w_ovr_inc && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign o_overrun_cnt = r_ovr_cnt;
`else
    logic w_unused_ovr;

    assign w_unused_ovr  = i_clr_overrun | w_ovr_inc;
    assign o_overrun_cnt = 8'h00;
`endif

    assign o_upd_sync = r_upd_sync;
    assign o_botinfo  = r_botinfo;
    assign o_queued   = r_queued;

endmodule

// File: tb/tb_bot_update_sync.sv
// ---------------------------------------------------------------------------
// tb_bot_update_sync
//
// Directed bench for bot_update_sync. Stimulus pushes the expected o_upd_sync
// transitions (edge index, level, snapshot, queued flag) into a scoreboard;
// a monitor on the falling clock edge pops and compares on every transition.
// Counter/queue levels are checked directly at milestones.
// ---------------------------------------------------------------------------
module tb_bot_update_sync;

`ifdef BOTUPD_OVERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        i_upd_sysregs;
    logic [7:0]  i_locx, i_locy, i_sensors, i_botinfo;
    logic        i_int_ack;
    logic        i_clr_overrun;
    logic        o_upd_sync;
    logic [31:0] o_botinfo;
    logic        o_queued;
    logic [7:0]  o_overrun_cnt;

    bot_update_sync #(.ACK_SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_upd_sysregs (i_upd_sysregs),
        .i_locx        (i_locx),
        .i_locy        (i_locy),
        .i_sensors     (i_sensors),
        .i_botinfo     (i_botinfo),
        .i_int_ack     (i_int_ack),
        .i_clr_overrun (i_clr_overrun),
        .o_upd_sync    (o_upd_sync),
        .o_botinfo     (o_botinfo),
        .o_queued      (o_queued),
        .o_overrun_cnt (o_overrun_cnt)
    );

    typedef struct {
        int          cyc;
        logic        lvl;
        logic [31:0] bot;
        logic        q;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_sync = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every o_upd_sync transition must match the next scoreboard entry.
    always @(negedge clk) begin
        if (o_upd_sync !== prev_sync) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected cyc=%0d upd_sync=%b bot=%h (no transition expected)",
                         cyc, o_upd_sync, o_botinfo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.lvl !== o_upd_sync || e.bot !== o_botinfo ||
                    (e.lvl && e.q !== o_queued)) begin
                    errors++;
                    $display("FAIL sb_transition got cyc=%0d lvl=%b bot=%h q=%b want cyc=%0d lvl=%b bot=%h q=%b",
                             cyc, o_upd_sync, o_botinfo, o_queued, e.cyc, e.lvl, e.bot, e.q);
                end
            end
            prev_sync = o_upd_sync;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic set_live(input logic [31:0] v);
        {i_locx, i_locy, i_sensors, i_botinfo} = v;
    endtask

    task automatic push(input int c, input logic l, input logic [31:0] b, input logic q);
        exp_t e;
        e.cyc = c; e.lvl = l; e.bot = b; e.q = q;
        sb.push_back(e);
    endtask

    task automatic pulse;
        i_upd_sysregs = 1'b1;
        tick;
        i_upd_sysregs = 1'b0;
        tick;
    endtask

    // Expects the fall 3 edges after ack is raised; optionally a re-assert
    // one edge later with snapshot nb.
    task automatic do_ack(input logic [31:0] held, input bit requeue, input logic [31:0] nb);
        int k;
        k = cyc;
        push(k + 3, 1'b0, held, 1'b0);
        if (requeue) push(k + 4, 1'b1, nb, 1'b0);
        i_int_ack = 1'b1;
        repeat (4) tick;
        i_int_ack = 1'b0;
        repeat (4) tick;
    endtask

    initial begin
        int k;
        rstn = 1'b0;
        i_upd_sysregs = 1'b0;
        i_int_ack = 1'b0;
        i_clr_overrun = 1'b0;
        set_live(32'h0);
        tick;
        chk("rst_upd_sync", o_upd_sync, 0);
        chk("rst_botinfo", o_botinfo, 0);
        chk("rst_queued", o_queued, 0);
        chk("rst_cnt", o_overrun_cnt, 0);
        tick;
        rstn = 1'b1;
        repeat (2) tick;

        // Reset while PEND with a queued update.
        set_live(32'hA5A5_1234);
        push(cyc + 1, 1'b1, 32'hA5A5_1234, 1'b0);
        pulse;
        pulse;
        chk("pre_rst_queued", o_queued, 1);
        rstn = 1'b0;
        push(cyc, 1'b0, 32'h0, 1'b0);
        #1;
        chk("async_rst_upd_sync", o_upd_sync, 0);
        chk("async_rst_botinfo", o_botinfo, 0);
        chk("async_rst_queued", o_queued, 0);
        chk("async_rst_cnt", o_overrun_cnt, 0);
        repeat (2) tick;
        rstn = 1'b1;
        repeat (3) tick;
        chk("post_rst_upd_sync", o_upd_sync, 0);
        chk("post_rst_queued", o_queued, 0);

        // Single update, snapshot holds while live regs change.
        set_live(32'h1020_0304);
        push(cyc + 1, 1'b1, 32'h1020_0304, 1'b0);
        pulse;
        set_live(32'hFFFF_FFFF);
        repeat (2) tick;
        chk("single_hold_bot", o_botinfo, 32'h1020_0304);
        do_ack(32'h1020_0304, 1'b0, 32'h0);
        chk("single_idle", o_upd_sync, 0);

        // Queued update recaptures live value at GAP time.
        set_live(32'h0000_0011);
        push(cyc + 1, 1'b1, 32'h0000_0011, 1'b0);
        pulse;
        set_live(32'h0000_00AA);
        pulse;
        chk("queue_set", o_queued, 1);
        set_live(32'h0000_00BB);
        do_ack(32'h0000_0011, 1'b1, 32'h0000_00BB);
        chk("queue_cleared", o_queued, 0);
        chk("queue_bot", o_botinfo, 32'h0000_00BB);
        do_ack(32'h0000_00BB, 1'b0, 32'h0);

        // Overrun counting, saturation and clear priority.
        set_live(32'h0000_0022);
        push(cyc + 1, 1'b1, 32'h0000_0022, 1'b0);
        pulse;
        for (int i = 1; i <= 5; i++) begin
            pulse;
            chk("ovr_queued", o_queued, 1);
            chk("ovr_cnt", o_overrun_cnt, CNT_EN ? 32'(i - 1) : 32'd0);
        end
        repeat (300) pulse;
        chk("ovr_sat", o_overrun_cnt, CNT_EN ? 32'hFF : 32'h0);
        chk("ovr_sat_queued", o_queued, 1);
        i_clr_overrun = 1'b1;
        i_upd_sysregs = 1'b1;
        tick;
        i_clr_overrun = 1'b0;
        i_upd_sysregs = 1'b0;
        tick;
        chk("ovr_clr_sat", o_overrun_cnt, 0);
        pulse;
        chk("ovr_after_clr", o_overrun_cnt, CNT_EN ? 32'd1 : 32'd0);
        i_clr_overrun = 1'b1;
        i_upd_sysregs = 1'b1;
        tick;
        i_clr_overrun = 1'b0;
        i_upd_sysregs = 1'b0;
        tick;
        chk("ovr_clr_prio", o_overrun_cnt, 0);
        set_live(32'h0000_0055);
        do_ack(32'h0000_0022, 1'b1, 32'h0000_0055);
        chk("ovr_requeue_q", o_queued, 0);
        do_ack(32'h0000_0055, 1'b0, 32'h0);

        // Update rise and ack rise in the same PEND cycle; upd held 10 cycles.
        set_live(32'h0000_0033);
        push(cyc + 1, 1'b1, 32'h0000_0033, 1'b0);
        pulse;
        set_live(32'h0000_0044);
        k = cyc;
        push(k + 3, 1'b0, 32'h0000_0033, 1'b0);
        push(k + 4, 1'b1, 32'h0000_0044, 1'b0);
        i_int_ack = 1'b1;
        repeat (2) tick;
        i_upd_sysregs = 1'b1;
        repeat (10) tick;
        i_upd_sysregs = 1'b0;
        i_int_ack = 1'b0;
        chk("simul_queued", o_queued, 0);
        chk("simul_cnt", o_overrun_cnt, 0);
        chk("simul_bot", o_botinfo, 32'h0000_0044);
        repeat (4) tick;
        do_ack(32'h0000_0044, 1'b0, 32'h0);

        repeat (3) tick;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bot_update_sync.md
# bot_update_sync

Rojobot update handshake stage between the rojobot (`upd_sysregs`, `LocX/LocY/Sensors/BotInfo` registers) and the core's GPIO interrupt inputs (`io_BotUpdt_Sync`, `io_BotInfo`, `io_INT_ACK`).
- On each update pulse it captures a coherent 32-bit snapshot of the rojobot registers and raises a sticky update flag.
- The flag holds until the core acknowledges.
- Updates that arrive while the core is still servicing one are queued (depth 1); surplus updates are counted as overruns.

## Interface
- `ACK_SYNC_STAGES`, default 2: synchronizer depth for `i_int_ack`. Legal range 2..4.
- `clk` in 1: rojobot clock. All logic is on its rising edge.
- `rstn` in 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is used as-is, since it is already synchronized by the clock generator.
- `i_upd_sysregs` in 1: rojobot update strobe, synchronous to `clk`. Can be multi-cycle; only the rising edge counts.
- `i_locx`, `i_locy`, `i_sensors`, `i_botinfo` in 8 each: live rojobot registers.
- `i_int_ack` in 1: core acknowledge, a GPIO level asynchronous to `clk`. Only its rising edge counts.
- `i_clr_overrun` in 1: synchronous clear of the overrun counter.
- `o_upd_sync` out 1: update pending / interrupt request to the core.
- `o_botinfo` out 32: snapshot `{locx, locy, sensors, botinfo}`.
- `o_queued` out 1: one further update is waiting behind the current one.
- `o_overrun_cnt` out 8: count of dropped updates, saturating.

## Operation
- Reset values: state IDLE; `o_upd_sync`=0; `o_botinfo`=0; `o_queued`=0; `o_overrun_cnt`=0; synchronizer and edge registers = 0.
- `upd_rise` = `i_upd_sysregs` & ~(its value registered last cycle).
- `ack_rise` = last synchronizer stage & ~(that stage registered one more cycle).
- IDLE:
  - On `upd_rise`: capture the live registers into `o_botinfo`, set `o_upd_sync`, go to PEND.
  - `ack_rise` in IDLE is ignored.
- PEND:
  - `o_upd_sync`=1 and `o_botinfo` frozen.
  - `upd_rise` with `o_queued`=0: set `o_queued`.
  - `upd_rise` with `o_queued`=1: overrun, counter +1.
  - `ack_rise`: clear `o_upd_sync`, go to GAP.
  - `upd_rise` and `ack_rise` in the same cycle: both actions apply. The update is queued (or counted as an overrun) and the state moves to GAP.
- GAP (exactly one cycle, `o_upd_sync`=0, guaranteeing the core sees a falling edge):
  - If `o_queued`=1, or `upd_rise` arrives this cycle: recapture the live registers (the value at that edge, not the value at queue time), clear `o_queued`, set `o_upd_sync`, go to PEND.
  - Otherwise go to IDLE.
- Overrun counter:
  - Saturates at 8'hFF.
  - `i_clr_overrun` has priority over an increment in the same cycle; the result is 0.
- Snapshot registers load only on the capture transitions above. `o_botinfo` is never partially updated.

## Timing
- Update latency: the `o_upd_sync` rise and the new `o_botinfo` appear on the edge that samples the `upd_rise` condition. Call that edge n+1 when the strobe is first high in cycle n.
- Ack latency: `o_upd_sync` falls `ACK_SYNC_STAGES`+1 edges after the first edge that samples `i_int_ack`=1. This is 3 edges at the default.
- Queued service: minimum low time of `o_upd_sync` is 1 cycle. It re-asserts on the edge after the GAP cycle.
- `i_int_ack` must stay high for at least `ACK_SYNC_STAGES`+1 `clk` periods. It must return low before the next acknowledge; a level held high produces no further edges.
- Reset mid-operation: all state clears immediately. A queued update is lost and is not counted.

## Configuration
- `BOTUPD_OVERRUN_CNT_EN`:
  - Defined: the 8-bit saturating counter and `i_clr_overrun` are implemented as described.
  - Undefined: no counter flops exist; `o_overrun_cnt` is tied to 8'h00 and `i_clr_overrun` is ignored.
  - Queue behaviour (`o_queued`, GAP recapture) is identical either way.

## Test plan
- **Reset:** drive live regs 32'hA5A5_1234, `rstn`=0 mid-PEND with `o_queued`=1. Required: all outputs go to 0 asynchronously and the state is IDLE after release.
- **Single update:** live = 32'h1020_0304, pulse `upd` for 1 cycle. Required: `o_upd_sync`=1 and `o_botinfo`=32'h1020_0304 on the next edge. Change the live regs; `o_botinfo` holds. Raise ack; `o_upd_sync`=0 exactly 3 edges later, then IDLE.
- **Queued update:** in PEND, pulse `upd` with live=32'h0000_00AA, then set live=32'h0000_00BB and ack. Required: `o_upd_sync` low for exactly 1 cycle, then high with `o_botinfo`=32'h0000_00BB and `o_queued`=0.
- **Overrun:** in PEND, issue 5 `upd` pulses. Required: `o_queued`=1 and `o_overrun_cnt`=4. Issue 300 more pulses; the counter reads 8'hFF. Assert `i_clr_overrun` together with a further `upd` pulse; the counter reads 0.
- **Simultaneous events:** `upd_rise` and `ack_rise` in the same PEND cycle with `o_queued`=0. Required: GAP for one cycle, then PEND with a new snapshot and no overrun. Holding `upd` high for 10 cycles counts as a single update.
- **Macro off:** build without `BOTUPD_OVERRUN_CNT_EN` and repeat the overrun scenario. Required: `o_overrun_cnt`=8'h00 throughout and `o_queued` behaviour unchanged.
